// File: rtl/vu_pkg.sv
// Shared constants and state encoding for the VU meter frame scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vu_pkg;

  localparam int VU_DATA_W      = 8;
  localparam int VU_DECAY       = 4;
  localparam int VU_PEAK_DECAY  = 2;
  localparam int VU_HOLD_FRAMES = 30;
  localparam int VU_HOLD_W      = 6;

  typedef enum logic {
    ACCUM  = 1'b0,
    COMMIT = 1'b1
  } vu_state_t;

endpackage

// File: rtl/vu_sat_decay.sv
// Decayed value: max(a, cur - STEP) with the subtraction clamped at zero.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module vu_sat_decay
  import vu_pkg::*;
#(
  parameter int DATA_W = VU_DATA_W,
  parameter int STEP   = VU_DECAY
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] cur,
  output logic [DATA_W-1:0] y
);

  localparam logic [DATA_W:0] STEP_EXT = (DATA_W+1)'(STEP);

  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] dec;

  // One extra bit catches the borrow so a small value floors at zero instead of wrapping.
  always_comb begin
    diff = {1'b0, cur} - STEP_EXT;
    dec  = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
    y    = (a > dec) ? a : dec;
  end

endmodule

// File: rtl/vu_frame_scheduler.sv
// Collects the loudest sample per video frame and commits level/peak once, at the start of vsync.
// Latency: a sample accepted before the vsync tick shows on level two cycles after the tick cycle.
// Backpressure: sample_ready drops for the single commit cycle; the source holds its sample.
module vu_frame_scheduler
  import vu_pkg::*;
#(
  parameter int DATA_W      = VU_DATA_W,
  parameter int DECAY       = VU_DECAY,
  parameter int PEAK_DECAY  = VU_PEAK_DECAY,
  parameter int HOLD_FRAMES = VU_HOLD_FRAMES,
  parameter int HOLD_W      = VU_HOLD_W,
  parameter bit V_POL       = 1'b0
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              v_sync,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [DATA_W-1:0] level,
  output logic [DATA_W-1:0] peak,
  output logic              frame_tick
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

  vu_state_t         state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_max;
  logic [HOLD_W-1:0] hold_cnt;
  logic              vs_prev;
  logic              tick;
  logic              accept;
  logic [DATA_W-1:0] level_dec;
  logic [DATA_W-1:0] peak_dec;

  // Start-of-vsync detect and sample acceptance; vga shares this clock so no synchroniser.
  always_comb begin
    tick    = (v_sync == V_POL) && (vs_prev != V_POL);
    accept  = sample_valid && sample_ready;
    acc_max = (sample > acc) ? sample : acc;
  end

  // max(acc, level - DECAY) already yields acc whenever acc >= level, so it is the whole level update.
  vu_sat_decay #(
    .DATA_W (DATA_W),
    .STEP   (DECAY)
  ) u_level_decay (
    .a   (acc),
    .cur (level),
    .y   (level_dec)
  );

  vu_sat_decay #(
    .DATA_W (DATA_W),
    .STEP   (PEAK_DECAY)
  ) u_peak_decay (
    .a   (acc),
    .cur (peak),
    .y   (peak_dec)
  );

  // Remember last v_sync so the inactive-to-active transition can be seen.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      vs_prev <= 1'b0;
    end else begin
      vs_prev <= v_sync;
    end
  end

  // Frame FSM: accumulate the frame maximum, then one commit cycle updates level, peak and hold.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state        <= ACCUM;
      sample_ready <= 1'b0;
      frame_tick   <= 1'b0;
      acc          <= '0;
      level        <= '0;
      peak         <= '0;
      hold_cnt     <= '0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        ACCUM: begin
          // A sample taken in the tick cycle still belongs to the frame being committed.
          if (accept) begin
            acc <= acc_max;
          end
          if (tick) begin
            state        <= COMMIT;
            sample_ready <= 1'b0;
            frame_tick   <= 1'b1;
          end else begin
            sample_ready <= 1'b1;
          end
        end
        COMMIT: begin
          level <= level_dec;
          if (acc >= peak) begin
            peak     <= acc;
            hold_cnt <= HOLD_INIT;
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else begin
            peak <= peak_dec;
          end
          acc          <= '0;
          state        <= ACCUM;
          sample_ready <= 1'b1;
        end
        default: begin
          state        <= ACCUM;
          sample_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vu_frame_scheduler.sv
// Scoreboard bench for vu_frame_scheduler: a frame-level model pushes expected level/peak/hold per commit.
// Latency: expected entries are popped one cycle after frame_tick is seen.
// Backpressure: the bench offers samples only when its model expects sample_ready high.
module tb_vu_frame_scheduler;

  localparam int DW = 8;
  localparam int HW = 6;

  typedef struct packed {
    logic [DW-1:0] lvl;
    logic [DW-1:0] pk;
    logic [HW-1:0] hold;
  } exp_t;

  logic          pixel_clock = 1'b0;
  logic          reset;
  logic          v_sync;
  logic [DW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready;
  logic [DW-1:0] level;
  logic [DW-1:0] peak;
  logic          frame_tick;

  exp_t exp_q[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   n_ticks  = 0;
  int   n_pushed = 0;
  logic pend     = 1'b0;

  // Model state
  logic [DW-1:0] m_acc, m_lvl, m_pk;
  logic [HW-1:0] m_hold;
  logic          m_vs_prev, m_commit_next, m_first;

  vu_frame_scheduler dut (
    .pixel_clock  (pixel_clock),
    .reset        (reset),
    .v_sync       (v_sync),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .level        (level),
    .peak         (peak),
    .frame_tick   (frame_tick)
  );

  always #5 pixel_clock = ~pixel_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mreset();
    m_acc         = '0;
    m_lvl         = '0;
    m_pk          = '0;
    m_hold        = '0;
    m_vs_prev     = 1'b0;
    m_commit_next = 1'b0;
    m_first       = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_commit();
    logic [DW:0] d;
    exp_t e;
    if (m_acc >= m_lvl) begin
      m_lvl = m_acc;
    end else begin
      d     = {1'b0, m_lvl} - 9'd4;
      m_lvl = d[DW] ? 8'd0 : d[DW-1:0];
      if (m_acc > m_lvl) m_lvl = m_acc;
    end
    if (m_acc >= m_pk) begin
      m_pk   = m_acc;
      m_hold = 6'd30;
    end else if (m_hold != 0) begin
      m_hold = m_hold - 6'd1;
    end else begin
      d    = {1'b0, m_pk} - 9'd2;
      m_pk = d[DW] ? 8'd0 : d[DW-1:0];
      if (m_acc > m_pk) m_pk = m_acc;
    end
    m_acc  = '0;
    e.lvl  = m_lvl;
    e.pk   = m_pk;
    e.hold = m_hold;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic vs, input logic vld, input logic [DW-1:0] smp);
    logic tk;
    v_sync       = vs;
    sample_valid = vld;
    sample       = smp;
    tk = (vs == 1'b0) && (m_vs_prev != 1'b0);
    if (m_commit_next) begin
      model_commit();
      m_commit_next = 1'b0;
    end else begin
      if (!m_first) begin
        check("ready_accum", sample_ready, 1);
        if (vld && smp > m_acc) m_acc = smp;
      end
      if (tk) m_commit_next = 1'b1;
    end
    m_first   = 1'b0;
    m_vs_prev = vs;
    @(posedge pixel_clock);
    #1;
  endtask

  // 8 visible cycles with up to 3 samples, then 3 vsync-active cycles.
  task automatic frame(input int ns, input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                       input logic [DW-1:0] s2, input logic [DW-1:0] sync_smp,
                       input logic sync_vld);
    logic          v;
    logic [DW-1:0] s;
    for (int i = 0; i < 8; i++) begin
      v = 1'b0;
      s = '0;
      if (i == 2 && ns > 0) begin v = 1'b1; s = s0; end
      if (i == 4 && ns > 1) begin v = 1'b1; s = s1; end
      if (i == 6 && ns > 2) begin v = 1'b1; s = s2; end
      step(1'b1, v, s);
    end
    for (int i = 0; i < 3; i++) step(1'b0, sync_vld, sync_smp);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    v_sync       = 1'b1;
    sample_valid = 1'b0;
    mreset();
    @(posedge pixel_clock);
    #1;
    check("rst_level", level, 0);
    check("rst_peak", peak, 0);
    reset = 1'b0;
  endtask

  // Commit monitor: frame_tick marks the commit cycle, results are checked one cycle later.
  always @(negedge pixel_clock) begin
    exp_t e;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("level", level, e.lvl);
          check("peak", peak, e.pk);
          check("hold_cnt", dut.hold_cnt, e.hold);
          check("tick_width", frame_tick, 0);
          check("peak_ge_level", peak >= level, 1);
        end
      end
      if (frame_tick) begin
        n_ticks++;
        check("ready_in_commit", sample_ready, 0);
        pend = 1'b1;
      end
    end
  end

  initial begin
    reset        = 1'b1;
    v_sync       = 1'b1;
    sample_valid = 1'b0;
    sample       = '0;
    mreset();
    #12;
    check("reset_level", level, 0);
    check("reset_peak", peak, 0);
    check("reset_tick", frame_tick, 0);
    check("reset_ready", sample_ready, 0);
    @(posedge pixel_clock);
    #1;
    reset = 1'b0;

    // Idle frames
    for (int f = 0; f < 3; f++) frame(0, 0, 0, 0, 0, 1'b0);
    // Attack, then decay against a quieter sample
    frame(3, 8'd10, 8'd200, 8'd50, 0, 1'b0);
    frame(1, 8'd100, 0, 0, 0, 1'b0);
    check("t2_level", level, 196);
    // Long silence: level decays to zero, peak holds then decays
    for (int f = 0; f < 52; f++) frame(0, 0, 0, 0, 0, 1'b0);
    check("t3_level_zero", level, 0);

    // Sample held valid through the tick: tick-cycle sample counted, later one carried over
    do_reset();
    frame(0, 0, 0, 0, 8'd77, 1'b1);
    check("t4_level", level, 77);
    frame(0, 0, 0, 0, 0, 1'b0);
    frame(0, 0, 0, 0, 0, 1'b0);

    // Saturating decay and full-scale sample
    do_reset();
    frame(1, 8'd3, 0, 0, 0, 1'b0);
    frame(0, 0, 0, 0, 0, 1'b0);
    check("t5_sat_level", level, 0);
    frame(1, 8'd255, 0, 0, 0, 1'b0);
    check("t5_full_level", level, 255);
    check("t5_full_peak", peak, 255);

    // Asynchronous reset in active video discards partial frame
    do_reset();
    frame(1, 8'd120, 0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 8'd150);
    step(1'b1, 1'b0, 8'd0);
    check("t6_pre_level", level, 120);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_level", level, 0);
    check("t6_async_peak", peak, 0);
    check("t6_async_tick", frame_tick, 0);
    mreset();
    v_sync = 1'b1;
    @(posedge pixel_clock);
    @(posedge pixel_clock);
    #1;
    reset = 1'b0;
    frame(1, 8'd40, 0, 0, 0, 1'b0);
    check("t6_post_level", level, 40);
    check("t6_post_peak", peak, 40);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);

    check("tick_count", n_ticks, n_pushed);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vu_frame_scheduler.md
Name: vu_frame_scheduler

Overview:
- Sits between the audio-level source and the vga block's data input.
- Collects incoming level samples during each video frame, then commits exactly once per frame, at the start of vertical sync.
- On commit it applies attack, decay and peak-hold, and presents a frame-stable level and peak to the renderer.
- Guarantees the circle radius never changes during active video.

Parameters:
- DATA_W, 8: sample/level width in bits.
- DECAY, 4: per-frame fall of level when no louder sample arrived.
- PEAK_DECAY, 2: per-frame fall of peak once its hold expires.
- HOLD_FRAMES, 30: frames the peak is held after being set.
- HOLD_W, 6: hold counter width; HOLD_FRAMES must be < 2**HOLD_W.
- V_POL, 0: v_sync active level (0 = negative polarity), matching vga.

Ports:
- pixel_clock  in  1  pixel clock, same clock as vga.
- reset  in  1  asynchronous, active-high reset.
- v_sync  in  1  registered vertical sync from vga.
- sample  in  DATA_W  unsigned level magnitude.
- sample_valid  in  1  sample is presented this cycle.
- sample_ready  out  1  block accepts a sample this cycle.
- level  out  DATA_W  committed meter level; drives vga data.
- peak  out  DATA_W  committed peak-hold value.
- frame_tick  out  1  one-cycle pulse in the commit cycle.

Behaviour:
- One clock domain; all state is in registers; reset is asynchronous and active-high.
- Reset values:
  - state = ACCUM.
  - acc, level, peak, hold_cnt, vs_prev = 0; sample_ready = 0 in the reset cycle, then follows state.
  - frame_tick = 0.
- Frame edge detect:
  - vs_prev <= v_sync every cycle.
  - tick = (v_sync == V_POL) && (vs_prev != V_POL).
  - Single pixel_clock domain, so no synchroniser is needed.
  - Out of reset, vs_prev = 0. With V_POL=0 the first low v_sync raises no tick; the first tick is the next inactive-to-active transition.
- FSM has 2 states.
- ACCUM:
  - sample_ready = 1.
  - On sample_valid, acc <= max(acc, sample).
  - On tick, go to COMMIT. A sample accepted in the tick cycle is folded into acc and is included in this commit.
- COMMIT (exactly 1 cycle):
  - sample_ready = 0; frame_tick = 1; samples offered are not accepted (source holds them).
  - level <= (acc >= level) ? acc : max(acc, level - DECAY), with the subtraction saturating at 0 and computed at DATA_W+1 bits.
  - Peak: if acc >= peak, then peak <= acc and hold_cnt <= HOLD_FRAMES.
  - Else if hold_cnt != 0, then hold_cnt <= hold_cnt - 1 and peak is unchanged.
  - Else peak <= max(acc, peak - PEAK_DECAY), saturating at 0.
  - acc <= 0; next state ACCUM.
  - A tick seen while in COMMIT is ignored. This cannot occur in legal timing: sync spans ≥2 lines.
- level and peak change only in the cycle after COMMIT, i.e. inside vertical sync, so they are stable across the entire visible frame.
- Latency:
  - A sample accepted ≥1 cycle before a tick appears on level 2 cycles after the tick cycle (tick cycle → COMMIT → registered output).
  - A sample accepted after the tick's COMMIT waits for the next frame.
- Invariants:
  - After any commit, peak >= level.
  - With no samples, level reaches 0 in ceil(level/DECAY) frames.
- Reset mid-frame or mid-COMMIT discards acc and all outputs immediately (asynchronous); no partial commit occurs.

Decomposition:
- Shared package vu_pkg holds:
  - default DATA_W, DECAY, PEAK_DECAY, HOLD_FRAMES and HOLD_W constants;
  - the state encoding (ACCUM=0, COMMIT=1).
- One sub-module, vu_sat_decay:
  - combinational, computes max(a, cur - step) with saturating subtract;
  - instantiated twice, for level and for peak.

Test Plan:
1. Reset then no samples, 3 frames -> level=0, peak=0, one frame_tick per frame, each exactly 1 cycle wide.
2. Samples 10, 200, 50 in frame 1 -> after tick: level=200, peak=200, hold_cnt=30. Next frame sample 100 -> level=196, peak=200.
3. No samples after level=200 -> level 196, 192, … reaches 0 after 50 frames. Peak holds 200 for 30 frames, then drops 198, 196, …, never below level.
4. sample_valid held high with 77 continuously through a tick -> sample_ready=0 in COMMIT only; sample in the tick cycle is counted (level=77); no sample lost or duplicated.
5. Saturation: level=3 with DECAY=4 and no samples -> level=0, not 255. Sample 255 -> level=255, peak=255.
6. Assert reset during active video with level=120 -> level, peak and frame_tick = 0 immediately; next tick commits only post-reset samples.
